// File: rtl/full_adder_selftest.sv
// Built-in self-test cell: sweeps all eight {in1,in2,cin} vectors through a
// 1-bit full adder and checks each result against an independent golden model.
module full_adder_selftest #(
   parameter int unsigned NUM_PASSES = 1,
   parameter int unsigned ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             fault_inject,
   output logic             in1,
   output logic             in2,
   output logic             cin,
   output logic             sum,
   output logic             cout,
   output logic [2:0]       vec_idx,
   output logic [ERR_W-1:0] err_count,
   output logic             mismatch,
   output logic             done,
   output logic             pass
);

   localparam int unsigned VEC_W  = 3;
   localparam int unsigned PCNT_W = 8;
   localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(7);
   localparam logic [PCNT_W-1:0] LAST_PASS = PCNT_W'(NUM_PASSES - 1);

   logic [VEC_W-1:0]  vec_q,      vec_d;
   logic [PCNT_W-1:0] pcnt_q,     pcnt_d;
   logic [ERR_W-1:0]  err_q,      err_d;
   logic              mismatch_q, mismatch_d;
   logic              done_q,     done_d;
   logic              pass_q,     pass_d;

   logic check_en;
   logic exp_sum;
   logic exp_cout;
   logic miss;

   // Operands are the bits of the current vector index.
   assign in1       = vec_q[2];
   assign in2       = vec_q[1];
   assign cin       = vec_q[0];
   assign vec_idx   = vec_q;
   assign err_count = err_q;
   assign mismatch  = mismatch_q;
   assign done      = done_q;
   assign pass      = pass_q;

   // Device under self-test: plain full adder with an optional sum inversion.
   assign sum  = in1 ^ in2 ^ cin ^ fault_inject;
   assign cout = (in1 & in2) | (in1 & cin) | (in2 & cin);

   // Golden model derived from the vector index, not from the adder netlist.
   assign exp_sum  = ^vec_q;
   assign exp_cout = (vec_q == VEC_W'(3)) || (vec_q == VEC_W'(5)) ||
                     (vec_q == VEC_W'(6)) || (vec_q == VEC_W'(7));

   assign check_en = enable & ~done_q;
   assign miss     = ({cout, sum} != {exp_cout, exp_sum});

   always_comb begin
      vec_d      = vec_q;
      pcnt_d     = pcnt_q;
      err_d      = err_q;
      mismatch_d = 1'b0;
      done_d     = done_q;
      pass_d     = pass_q;

      if (check_en) begin
         mismatch_d = miss;
         if (miss && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
         end
         // The final vector of the final pass parks the sweep at vector 7.
         if ((vec_q == LAST_VEC) && (pcnt_q == LAST_PASS)) begin
            done_d = 1'b1;
         end else begin
            vec_d = vec_q + VEC_W'(1);
            if (vec_q == LAST_VEC) begin
               pcnt_d = pcnt_q + PCNT_W'(1);
            end
         end
      end

      pass_d = done_d & (err_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q      <= '0;
         pcnt_q     <= '0;
         err_q      <= '0;
         mismatch_q <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         vec_q      <= vec_d;
         pcnt_q     <= pcnt_d;
         err_q      <= err_d;
         mismatch_q <= mismatch_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

endmodule

// File: tb/tb_full_adder_selftest.sv
// Scoreboard bench for full_adder_selftest: two instances (1 pass / 8-bit
// errors and 2 passes / 3-bit errors) run in lockstep against a step-count model.
module tb_full_adder_selftest;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
   logic fault_inject = 1'b0;

   logic       in1_a, in2_a, cin_a, sum_a, cout_a, mis_a, done_a, pass_a;
   logic [2:0] vec_a;
   logic [7:0] err_a;
   logic       in1_b, in2_b, cin_b, sum_b, cout_b, mis_b, done_b, pass_b;
   logic [2:0] vec_b;
   logic [2:0] err_b;

   full_adder_selftest #(.NUM_PASSES(1), .ERR_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .fault_inject(fault_inject),
      .in1(in1_a), .in2(in2_a), .cin(cin_a), .sum(sum_a), .cout(cout_a),
      .vec_idx(vec_a), .err_count(err_a), .mismatch(mis_a), .done(done_a), .pass(pass_a));

   full_adder_selftest #(.NUM_PASSES(2), .ERR_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .fault_inject(fault_inject),
      .in1(in1_b), .in2(in2_b), .cin(cin_b), .sum(sum_b), .cout(cout_b),
      .vec_idx(vec_b), .err_count(err_b), .mismatch(mis_b), .done(done_b), .pass(pass_b));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Expected record: {in1,in2,cin,sum,cout} before the edge, {vec,mis,done,pass,err} after it.
   typedef struct packed {
      logic [18:0] e_a;
      logic [18:0] e_b;
   } rec_t;
   rec_t sb_q[$];

   // Model state: number of checks done so far, error total, done flag.
   int unsigned mk[2];
   int unsigned merr[2];
   bit          mdone[2];
   int unsigned np[2]   = '{1, 2};
   int unsigned emax[2] = '{255, 7};

   function automatic logic [4:0] exp_pre(int unsigned k, bit flt);
      logic [2:0] v;
      int ones;
      v    = 3'(k % 8);
      ones = $countones(v);
      return {v, 1'((ones % 2) == 1) ^ flt, 1'(ones >= 2)};
   endfunction

   function automatic logic [13:0] exp_post(int unsigned k, bit mis, bit dn, int unsigned err);
      return {3'(k % 8), mis, dn, dn && (err == 0), 8'(err)};
   endfunction

   task automatic check(string name, logic [18:0] act, logic [18:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   // One clock cycle of stimulus; do_rst pulses reset between the edges.
   task automatic cycle(bit en, bit flt, bit do_rst);
      logic [4:0]  pre[2];
      logic [13:0] post[2];
      rec_t r;
      @(negedge clk);
      rst_n        = 1'b1;
      enable       = en;
      fault_inject = flt;
      for (int i = 0; i < 2; i++) begin
         pre[i] = exp_pre(mk[i], flt);
         if (do_rst) begin
            mk[i] = 0; merr[i] = 0; mdone[i] = 0;
            post[i] = '0;
         end else begin
            bit chk, mis;
            chk = en && !mdone[i];
            mis = chk && flt;
            if (chk) begin
               if (flt && merr[i] < emax[i]) merr[i]++;
               if (mk[i] == 8 * np[i] - 1) mdone[i] = 1'b1;
               else mk[i]++;
            end
            post[i] = exp_post(mk[i], mis, mdone[i], merr[i]);
         end
      end
      r.e_a = {pre[0], post[0]};
      r.e_b = {pre[1], post[1]};
      sb_q.push_back(r);
      if (do_rst) begin
         #3 rst_n = 1'b0;
         #1;
         check("async_reset_a", {in1_a, in2_a, cin_a, 2'b00, vec_a, mis_a, done_a, pass_a, err_a}, '0);
         check("async_reset_b", {in1_b, in2_b, cin_b, 2'b00, vec_b, mis_b, done_b, pass_b, 5'b0, err_b}, '0);
      end
   endtask

   task automatic run(int n, int mode);
      bit en, flt;
      for (int c = 0; c < n; c++) begin
         case (mode)
            0: begin en = 1'b1; flt = 1'b0; end
            1: begin en = 1'b1; flt = 1'b1; end
            2: begin en = 1'b1; flt = (mk[0] % 8 == 3) && !mdone[0]; end
            3: begin en = (c % 3 == 0); flt = 1'b0; end
            default: begin en = 1'($urandom_range(0, 3) != 0); flt = 1'($urandom_range(0, 3) == 0); end
         endcase
         cycle(en, flt, 1'b0);
      end
   endtask

   // Monitor: samples adder outputs mid-cycle and registers after each edge.
   initial begin
      logic [4:0] pa, pb;
      rec_t r;
      forever begin
         @(negedge clk);
         #2;
         pa = {in1_a, in2_a, cin_a, sum_a, cout_a};
         pb = {in1_b, in2_b, cin_b, sum_b, cout_b};
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL monitor_underflow actual=empty required=record at %0t", $time);
         end else begin
            r = sb_q.pop_front();
            check("cycle_a", {pa, vec_a, mis_a, done_a, pass_a, err_a}, r.e_a);
            check("cycle_b", {pb, vec_b, mis_b, done_b, pass_b, 5'b0, err_b}, r.e_b);
         end
      end
   end

   initial begin
      cycle(1'b0, 1'b0, 1'b1); run(18, 0);
      cycle(1'b0, 1'b0, 1'b1); run(18, 1);
      cycle(1'b0, 1'b0, 1'b1); run(18, 2);
      cycle(1'b0, 1'b0, 1'b1); run(50, 3);
      cycle(1'b0, 1'b0, 1'b1); run(5, 0);
      cycle(1'b1, 1'b0, 1'b1); run(18, 0);
      repeat (3) begin
         cycle(1'b0, 1'b0, 1'b1); run(40, 4);
      end
      cycle(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      n_checks++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/full_adder_selftest.md
Name: full_adder_selftest

Overview:
Self-checking 1-bit full-adder block with three parts: a clocked stimulus generator, a combinational full adder (sum and carry), and a clocked checker. The stimulus sweeps all 8 combinations of (in1, in2, cin). The checker compares the adder outputs against a golden model and reports done, pass and error count. It serves as a built-in self-test cell and as a reference for adder-cell verification flows.

Parameters:
NUM_PASSES, 1, number of full 8-vector sweeps before done; legal range 1..255
ERR_W, 8, width of the error counter; the counter saturates at 2^ERR_W-1

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
enable  input  1  when 1, stimulus advances and checker evaluates each cycle; when 0, the block holds state
fault_inject  input  1  when 1, the adder sum output is inverted, used to exercise the checker
in1  output  1  stimulus operand A, drives the adder
in2  output  1  stimulus operand B, drives the adder
cin  output  1  stimulus carry-in, drives the adder
sum  output  1  adder sum, combinational
cout  output  1  adder carry-out, combinational
vec_idx  output  3  index of the vector currently applied, equal to {in1,in2,cin}
err_count  output  ERR_W  number of mismatching vectors, saturating
mismatch  output  1  registered; 1 for one cycle after a failing comparison
done  output  1  sticky; 1 after the final vector of the final pass has been checked
pass  output  1  equals done AND (err_count == 0)

Behaviour:
- Reset (rst_n=0, asynchronous): the following all go to 0, with no clock required:
  - vec_idx, pass counter, in1, in2, cin
  - err_count, mismatch, done, pass
- On rst_n deassertion, the first rising edge with enable=1 evaluates vector 0.
- Adder, purely combinational:
  - sum = in1 XOR in2 XOR cin, inverted when fault_inject=1.
  - cout = majority(in1, in2, cin); fault_inject does not affect cout.
- Golden model inside the checker is independent of fault_inject:
  - exp_sum = XOR of the three operands.
  - exp_cout = majority of the three operands.
- Each rising edge with enable=1 and done=0 does the following in one cycle:
  - Compare {cout,sum} with {exp_cout,exp_sum} for the currently applied vector.
  - On a difference: err_count increments (saturating) and mismatch=1 next cycle. Otherwise mismatch=0 next cycle.
  - Advance vec_idx by 1, wrapping 7->0. When it wraps, increment the pass counter.
  - If the checked vector was 7 and the pass counter equals NUM_PASSES-1: set done=1 instead of advancing. vec_idx stays at 7.
- enable=0: vec_idx, err_count and done hold. mismatch clears to 0. No comparison is made.
- Once done=1, the block ignores enable and all outputs freeze until reset. The only exception is mismatch, which clears to 0.
- Latency:
  - Adder outputs follow operands with zero cycles.
  - mismatch and err_count update on the edge that checks the vector.
  - done rises on the edge that checks the final vector.
  - The complete run takes 8*NUM_PASSES enabled cycles.
- Reset asserted mid-run aborts the run. All state clears immediately, and the next run restarts from vector 0, pass 0.
- fault_inject may toggle at any time. It affects only the comparisons made while it is high.
- err_count saturation: once at 2^ERR_W-1, the counter holds at that value on further mismatches.

Test Plan:
- Reset then enable=1 for 8 cycles, fault_inject=0, NUM_PASSES=1 -> vectors 0..7 applied. Sums are 0,1,1,0,1,0,0,1 and couts are 0,0,0,1,0,1,1,1. done=1 after the 8th edge, pass=1, err_count=0.
- fault_inject=1 for the whole run -> err_count=8, mismatch high after every check, done=1, pass=0.
- fault_inject=1 only while vec_idx=3 -> err_count=1, a single one-cycle mismatch pulse, pass=0.
- enable toggled 1,0,0,1,... -> vec_idx holds during the low cycles, and done arrives after exactly 8 enabled edges with pass=1.
- Assert rst_n=0 at vec_idx=5 between clock edges -> all outputs go to 0 immediately. Rerun completes with pass=1.
- NUM_PASSES=2, ERR_W=3, fault_inject=1 -> done after 16 enabled edges, err_count saturates at 7, pass=0.
